// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, issues one word-aligned fetch at a time
// to instruction memory and hands each fetched word with its PC to decode.
module fetch_unit #(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,

    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,

    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc,

    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            align_err
);

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] pc_seq;
    logic [XLEN-1:0] redirect_target;
    logic [XLEN-1:0] req_pc;
    logic [XLEN-1:0] req_pc_next;
    logic [XLEN-1:0] inst_data_next;
    logic [XLEN-1:0] inst_pc_next;
    logic            drop;
    logic            drop_next;
    logic            inst_valid_next;
    logic            align_err_next;
    logic            started;
    logic            req_fire;

    // The request is held off for the first cycle out of reset so that
    // imem_req_valid stays low while rst_n is asserted.
    assign imem_req_valid  = started && (state == REQ);
    assign imem_req_addr   = {pc[XLEN-1:2], 2'b00};
    assign req_fire        = imem_req_valid && imem_req_ready;
    assign pc_seq          = pc + XLEN'(4);
    assign redirect_target = {redirect_pc[XLEN-1:2], 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= REQ;
            pc         <= RESET_PC;
            req_pc     <= RESET_PC;
            drop       <= 1'b0;
            started    <= 1'b0;
            inst_valid <= 1'b0;
            inst_data  <= '0;
            inst_pc    <= '0;
            align_err  <= 1'b0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            req_pc     <= req_pc_next;
            drop       <= drop_next;
            started    <= 1'b1;
            inst_valid <= inst_valid_next;
            inst_data  <= inst_data_next;
            inst_pc    <= inst_pc_next;
            align_err  <= align_err_next;
        end
    end

    // Redirect wins over everything; a request already in flight is marked so its
    // response is thrown away instead of reaching decode.
    always_comb begin
        state_next      = state;
        pc_next         = pc;
        req_pc_next     = req_pc;
        drop_next       = drop;
        inst_valid_next = inst_valid;
        inst_data_next  = inst_data;
        inst_pc_next    = inst_pc;
        align_err_next  = 1'b0;

        if (redirect_valid) begin
            pc_next        = redirect_target;
            align_err_next = |redirect_pc[1:0];
            case (state)
                REQ: begin
                    if (req_fire) begin
                        req_pc_next = pc;
                        drop_next   = 1'b1;
                        state_next  = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        drop_next  = 1'b0;
                        state_next = REQ;
                    end else begin
                        drop_next  = 1'b1;
                    end
                end
                HOLD: begin
                    inst_valid_next = 1'b0;
                    state_next      = REQ;
                end
                default: begin
                    state_next = REQ;
                end
            endcase
        end else begin
            case (state)
                REQ: begin
                    if (req_fire) begin
                        req_pc_next = pc;
                        pc_next     = pc_seq;
                        state_next  = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        if (drop) begin
                            drop_next  = 1'b0;
                            state_next = REQ;
                        end else begin
                            inst_data_next  = imem_rsp_data;
                            inst_pc_next    = req_pc;
                            inst_valid_next = 1'b1;
                            state_next      = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (inst_ready) begin
                        inst_valid_next = 1'b0;
                        state_next      = REQ;
                    end
                end
                default: begin
                    state_next = REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a small latency-programmable
// instruction memory responder.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        align_err;

    int compared = 0;
    int mismatched = 0;

    int          mem_lat = 1;
    bit          rsp_pending = 1'b0;
    int          rsp_cnt = 0;
    logic [31:0] rsp_addr = 32'h0;
    logic [31:0] req_log[$];
    bit          overlap_en = 1'b1;
    int          overlap_err = 0;

    always #5 clk = ~clk;

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .align_err      (align_err)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    // Memory model: a request seen valid&ready at the falling edge is accepted on the
    // next rising edge; its response is driven mem_lat cycles after acceptance.
    always @(negedge clk) begin
        if (overlap_en && imem_req_valid && (rsp_pending || inst_valid))
            overlap_err++;
        imem_rsp_valid = 1'b0;
        if (rsp_pending) begin
            if (rsp_cnt == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(rsp_addr);
                rsp_pending    = 1'b0;
            end else begin
                rsp_cnt--;
            end
        end
        if (imem_req_valid && imem_req_ready) begin
            rsp_pending = 1'b1;
            rsp_cnt     = mem_lat - 1;
            rsp_addr    = imem_req_addr;
            req_log.push_back(imem_req_addr);
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation still running, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        repeat (5) tick();
        req_log.delete();
        rst_n = 1'b1;
    endtask

    task automatic wait_inst(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (inst_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        imem_req_ready = 1'b1;
        inst_ready = 1'b1;
        repeat (3) tick();
        compared++;
        if (imem_req_valid !== 1'b0) begin
            mismatched++; $display("[TB] FAIL rst_req_valid: got %b expected 0", imem_req_valid);
        end
        compared++;
        if (imem_req_addr !== 32'h0) begin
            mismatched++; $display("[TB] FAIL rst_req_addr: got %h expected 00000000", imem_req_addr);
        end
        compared++;
        if (inst_valid !== 1'b0) begin
            mismatched++; $display("[TB] FAIL rst_inst_valid: got %b expected 0", inst_valid);
        end
        compared++;
        if (inst_data !== 32'h0 || inst_pc !== 32'h0) begin
            mismatched++; $display("[TB] FAIL rst_inst_regs: got data=%h pc=%h expected 0/0", inst_data, inst_pc);
        end
        compared++;
        if (align_err !== 1'b0) begin
            mismatched++; $display("[TB] FAIL rst_align_err: got %b expected 0", align_err);
        end
        rst_n = 1'b1;
        #1;
        compared++;
        if (imem_req_valid !== 1'b0) begin
            mismatched++; $display("[TB] FAIL rst_release_valid: got %b expected 0", imem_req_valid);
        end
        tick();
        compared++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL first_req: got valid=%b addr=%h expected 1/00000000", imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_sequential();
        bit ok;
        logic [31:0] exp_pc;
        for (int k = 0; k < 3; k++) begin
            exp_pc = 32'(k * 4);
            wait_inst(ok);
            compared++;
            if (!ok || inst_pc !== exp_pc || inst_data !== mem_word(exp_pc)) begin
                mismatched++;
                $display("[TB] FAIL seq_inst%0d: got ok=%0d pc=%h data=%h expected pc=%h data=%h",
                         k, ok, inst_pc, inst_data, exp_pc, mem_word(exp_pc));
            end
            tick();
        end
        compared++;
        if (req_log.size() < 3 || req_log[0] !== 32'h0 || req_log[1] !== 32'h4 || req_log[2] !== 32'h8) begin
            mismatched++;
            $display("[TB] FAIL seq_req_addrs: got %0d requests, expected 0,4,8 first", req_log.size());
        end
        compared++;
        if (overlap_err !== 0) begin
            mismatched++; $display("[TB] FAIL seq_no_overlap: got %0d overlapping requests expected 0", overlap_err);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int n;
        imem_req_ready = 1'b1;
        inst_ready = 1'b1;
        do_reset();
        wait_inst(ok);
        tick();
        inst_ready = 1'b0;
        wait_inst(ok);
        compared++;
        if (!ok || inst_pc !== 32'h4 || inst_data !== mem_word(32'h4)) begin
            mismatched++;
            $display("[TB] FAIL bp_inst4: got ok=%0d pc=%h data=%h expected pc=00000004", ok, inst_pc, inst_data);
        end
        n = req_log.size();
        for (int c = 0; c < 5; c++) begin
            tick();
            compared++;
            if (inst_valid !== 1'b1 || inst_pc !== 32'h4 || inst_data !== mem_word(32'h4) || imem_req_valid !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL bp_hold%0d: got valid=%b pc=%h data=%h req=%b expected 1/00000004/%h/0",
                         c, inst_valid, inst_pc, inst_data, imem_req_valid, mem_word(32'h4));
            end
        end
        compared++;
        if (req_log.size() != n) begin
            mismatched++; $display("[TB] FAIL bp_no_req: got %0d requests expected %0d", req_log.size(), n);
        end
        inst_ready = 1'b1;
        tick();
        wait_inst(ok);
        compared++;
        if (!ok || inst_pc !== 32'h8 || req_log.size() <= n || req_log[n] !== 32'h8) begin
            mismatched++;
            $display("[TB] FAIL bp_release: got ok=%0d pc=%h expected pc=00000008 and request at 00000008", ok, inst_pc);
        end
    endtask

    task automatic test_redirect_wait();
        bit ok;
        int n;
        mem_lat = 2;
        do_reset();
        wait_inst(ok); tick();
        wait_inst(ok); tick();
        compared++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8) begin
            mismatched++;
            $display("[TB] FAIL rw_req8: got valid=%b addr=%h expected 1/00000008", imem_req_valid, imem_req_addr);
        end
        tick();
        compared++;
        if (imem_req_valid !== 1'b0) begin
            mismatched++; $display("[TB] FAIL rw_in_wait: got req_valid=%b expected 0", imem_req_valid);
        end
        n = req_log.size();
        redirect_valid = 1'b1;
        redirect_pc = 32'h64;
        tick();
        redirect_valid = 1'b0;
        wait_inst(ok);
        compared++;
        if (!ok || inst_pc !== 32'h64 || inst_data !== mem_word(32'h64)) begin
            mismatched++;
            $display("[TB] FAIL rw_first: got ok=%0d pc=%h data=%h expected pc=00000064 data=%h",
                     ok, inst_pc, inst_data, mem_word(32'h64));
        end
        tick();
        wait_inst(ok);
        compared++;
        if (!ok || inst_pc !== 32'h68 || inst_data !== mem_word(32'h68)) begin
            mismatched++;
            $display("[TB] FAIL rw_second: got ok=%0d pc=%h expected pc=00000068", ok, inst_pc);
        end
        compared++;
        if (req_log.size() <= n || req_log[n] !== 32'h64) begin
            mismatched++; $display("[TB] FAIL rw_req_target: got %0d requests, expected next request at 00000064", req_log.size());
        end
        mem_lat = 1;
    endtask

    task automatic test_redirect_hold();
        bit ok;
        inst_ready = 1'b1;
        do_reset();
        wait_inst(ok);
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect_valid = 1'b0;
        compared++;
        if (inst_valid !== 1'b0 || align_err !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL rh_drop: got inst_valid=%b align_err=%b expected 0/0", inst_valid, align_err);
        end
        compared++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin
            mismatched++;
            $display("[TB] FAIL rh_req: got valid=%b addr=%h expected 1/00000100", imem_req_valid, imem_req_addr);
        end
        wait_inst(ok);
        compared++;
        if (!ok || inst_pc !== 32'h100 || inst_data !== mem_word(32'h100)) begin
            mismatched++;
            $display("[TB] FAIL rh_next: got ok=%0d pc=%h data=%h expected pc=00000100", ok, inst_pc, inst_data);
        end
        tick();
    endtask

    task automatic test_align();
        bit ok;
        do_reset();
        wait_inst(ok);
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h66;
        tick();
        redirect_valid = 1'b0;
        compared++;
        if (align_err !== 1'b1) begin
            mismatched++; $display("[TB] FAIL al_pulse: got align_err=%b expected 1", align_err);
        end
        compared++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h64) begin
            mismatched++;
            $display("[TB] FAIL al_addr: got valid=%b addr=%h expected 1/00000064", imem_req_valid, imem_req_addr);
        end
        tick();
        compared++;
        if (align_err !== 1'b0) begin
            mismatched++; $display("[TB] FAIL al_one_cycle: got align_err=%b expected 0", align_err);
        end
        wait_inst(ok);
        compared++;
        if (!ok || inst_pc !== 32'h64 || inst_data !== mem_word(32'h64)) begin
            mismatched++;
            $display("[TB] FAIL al_inst: got ok=%0d pc=%h expected pc=00000064", ok, inst_pc);
        end
        tick();
    endtask

    task automatic test_wrap();
        bit ok;
        imem_req_ready = 1'b0;
        do_reset();
        tick();
        tick();
        compared++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL wr_stall: got valid=%b addr=%h expected 1/00000000", imem_req_valid, imem_req_addr);
        end
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        compared++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC || align_err !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL wr_addr: got valid=%b addr=%h align=%b expected 1/fffffffc/0",
                     imem_req_valid, imem_req_addr, align_err);
        end
        imem_req_ready = 1'b1;
        wait_inst(ok);
        compared++;
        if (!ok || inst_pc !== 32'hFFFF_FFFC || inst_data !== mem_word(32'hFFFF_FFFC)) begin
            mismatched++;
            $display("[TB] FAIL wr_top: got ok=%0d pc=%h data=%h expected pc=fffffffc data=%h",
                     ok, inst_pc, inst_data, mem_word(32'hFFFF_FFFC));
        end
        tick();
        wait_inst(ok);
        compared++;
        if (!ok || inst_pc !== 32'h0 || inst_data !== mem_word(32'h0)) begin
            mismatched++;
            $display("[TB] FAIL wr_wrap: got ok=%0d pc=%h expected pc=00000000", ok, inst_pc);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        bit ok;
        int n;
        imem_req_ready = 1'b1;
        inst_ready = 1'b1;
        mem_lat = 3;
        do_reset();
        tick();
        tick();
        compared++;
        if (imem_req_valid !== 1'b0) begin
            mismatched++; $display("[TB] FAIL rm_in_wait: got req_valid=%b expected 0", imem_req_valid);
        end
        overlap_en = 1'b0;
        rst_n = 1'b0;
        #1;
        compared++;
        if (imem_req_valid !== 1'b0 || imem_req_addr !== 32'h0 || inst_valid !== 1'b0 || align_err !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL rm_async: got req_valid=%b addr=%h inst_valid=%b align=%b expected 0/00000000/0/0",
                     imem_req_valid, imem_req_addr, inst_valid, align_err);
        end
        imem_req_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        compared++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL rm_first_req: got valid=%b addr=%h expected 1/00000000", imem_req_valid, imem_req_addr);
        end
        tick();
        compared++;
        if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL rm_stale_ignored: got inst_valid=%b req_valid=%b expected 0/1", inst_valid, imem_req_valid);
        end
        mem_lat = 1;
        n = req_log.size();
        imem_req_ready = 1'b1;
        wait_inst(ok);
        compared++;
        if (!ok || inst_pc !== 32'h0 || inst_data !== mem_word(32'h0) || req_log.size() <= n || req_log[n] !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL rm_refetch: got ok=%0d pc=%h data=%h expected pc=00000000 data=%h",
                     ok, inst_pc, inst_data, mem_word(32'h0));
        end
        tick();
        overlap_en = 1'b1;
    endtask

    initial begin
        $display("[TB] fetch_unit directed tests starting");
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_wait();
        test_redirect_hold();
        test_align();
        test_wrap();
        test_reset_mid();
        compared++;
        if (overlap_err !== 0) begin
            mismatched++; $display("[TB] FAIL no_overlap_total: got %0d overlapping requests expected 0", overlap_err);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
